// File: rtl/div_result_corrector.sv
// div_result_corrector
// Post-correction stage for a non-restoring divider. A raw quotient and
// partial remainder are captured, the remainder is fixed up when negative
// (r + m) and divide-by-zero is flagged. Results are queued in a small FIFO
// towards the consumer.
// Optional feature: define DIV_RESULT_CORR_CNT_EN to add the 8-bit saturating
// corr_cnt output, which counts results that needed remainder correction.
module div_result_corrector #(
  parameter int WQ    = 4,
  parameter int WR    = 5,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WQ-1:0] in_q,
  input  logic [WR-1:0] in_r,
  input  logic [WR-1:0] in_m,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WQ-1:0] out_q,
  output logic [WR-1:0] out_r,
  output logic          out_fix,
  output logic          out_dz
`ifdef DIV_RESULT_CORR_CNT_EN
  ,
  output logic [7:0]    corr_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = WQ + WR + 2;

  typedef enum logic [1:0] {
    IDLE,
    FIX,
    PUSH
  } state_t;

  state_t        state;

  logic [WQ-1:0] cap_q;
  logic [WR-1:0] cap_r;
  logic [WR-1:0] cap_m;

  logic [WQ-1:0] res_q;
  logic [WR-1:0] res_r;
  logic          res_fix;
  logic          res_dz;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          full;
  logic          accept;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Handshake qualifiers; in_ready only in IDLE with room left, never in reset
  always_comb begin
    full      = (count == CW'(DEPTH));
    in_ready  = !rst && (state == IDLE) && !full;
    accept    = in_valid && in_ready;
    push      = !rst && (state == PUSH);
    out_valid = !rst && (count != '0);
    pop       = out_valid && out_ready;
  end

  // Present the FIFO head, forced to zero when the FIFO is empty or in reset
  always_comb begin
    head = out_valid ? mem[rd_ptr] : '0;
    {out_q, out_r, out_fix, out_dz} = head;
  end

  // Control FSM: capture in IDLE, correct in FIX, hand over to the FIFO in PUSH
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cap_q   <= '0;
      cap_r   <= '0;
      cap_m   <= '0;
      res_q   <= '0;
      res_r   <= '0;
      res_fix <= 1'b0;
      res_dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_q <= in_q;
            cap_r <= in_r;
            cap_m <= in_m;
            state <= FIX;
          end
        end
        FIX: begin
          if (cap_m == '0) begin
            res_q   <= '1;
            res_r   <= cap_r;
            res_fix <= 1'b0;
            res_dz  <= 1'b1;
          end else if (cap_r[WR-1]) begin
            res_q   <= cap_q;
            res_r   <= cap_r + cap_m;
            res_fix <= 1'b1;
            res_dz  <= 1'b0;
          end else begin
            res_q   <= cap_q;
            res_r   <= cap_r;
            res_fix <= 1'b0;
            res_dz  <= 1'b0;
          end
          state <= PUSH;
        end
        PUSH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset because the head is masked when empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {res_q, res_r, res_fix, res_dz};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DIV_RESULT_CORR_CNT_EN
  // Saturating count of corrected results written into the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt <= 8'h00;
    end else if (push && res_fix && (corr_cnt != 8'hFF)) begin
      corr_cnt <= corr_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div_result_corrector.sv
// Testbench for div_result_corrector: randomized and directed stimulus with a
// queue-based scoreboard. Expected results come from a plain arithmetic model
// of the correction rules. Define DIV_RESULT_CORR_CNT_EN to also exercise
// the corr_cnt output.
module tb_div_result_corrector;

  localparam int WQ    = 4;
  localparam int WR    = 5;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [WQ-1:0] q;
    logic [WR-1:0] r;
    logic          fix;
    logic          dz;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [WQ-1:0] in_q;
  logic [WR-1:0] in_r;
  logic [WR-1:0] in_m;
  logic          out_valid;
  logic          out_ready;
  logic [WQ-1:0] out_q;
  logic [WR-1:0] out_r;
  logic          out_fix;
  logic          out_dz;
`ifdef DIV_RESULT_CORR_CNT_EN
  logic [7:0]    corr_cnt;
`endif

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   rand_mode = 0;
  time  acc_time = 0;

  div_result_corrector #(
    .WQ(WQ),
    .WR(WR),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_q(in_q),
    .in_r(in_r),
    .in_m(in_m),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q(out_q),
    .out_r(out_r),
    .out_fix(out_fix),
    .out_dz(out_dz)
`ifdef DIV_RESULT_CORR_CNT_EN
    ,
    .corr_cnt(corr_cnt)
`endif
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: divide-by-zero, negative remainder fixed by adding m, else pass-through
  function automatic exp_t model(input logic [WQ-1:0] q, input logic [WR-1:0] r,
                                 input logic [WR-1:0] m);
    exp_t e;
    int   rs;
    int   ms;
    rs = int'($signed(r));
    ms = int'($signed(m));
    if (m == 0) begin
      e.q = 4'hF; e.r = r; e.fix = 1'b0; e.dz = 1'b1;
    end else if (rs < 0) begin
      e.q = q; e.r = 5'((rs + ms) & 31); e.fix = 1'b1; e.dz = 1'b0;
    end else begin
      e.q = q; e.r = r; e.fix = 1'b0; e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Offer one result, wait (bounded) for acceptance, record the expected response
  task automatic applyStimulus(input logic [WQ-1:0] q, input logic [WR-1:0] r,
                               input logic [WR-1:0] m);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_q = q;
    in_r = r;
    in_m = m;
    #1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("accept", 32'(in_ready), 32'd1);
    if (in_ready) begin
      exp_q.push_back(model(q, r, m));
      @(posedge clk);
      acc_time = $time;
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Let everything queued reach the consumer with out_ready held high
  task automatic drain();
    int waited = 0;
    rand_mode = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    #2;
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Random consumer backpressure while rand_mode is set
  initial begin
    forever begin
      @(negedge clk);
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare every popped head against the scoreboard, empty outputs must be zero
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_out", 32'(out_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("out_q", 32'(out_q), 32'(e.q));
            checkOutput("out_r", 32'(out_r), 32'(e.r));
            checkOutput("out_fix", 32'(out_fix), 32'(e.fix));
            checkOutput("out_dz", 32'(out_dz), 32'(e.dz));
          end
        end else if (!out_valid) begin
          checkOutput("empty_zero", 32'({out_q, out_r, out_fix, out_dz}), 32'd0);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Main sequence
  initial begin
    time t0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_q = '0;
    in_r = '0;
    in_m = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_outputs", 32'({out_q, out_r, out_fix, out_dz}), 32'd0);
`ifdef DIV_RESULT_CORR_CNT_EN
    checkOutput("rst_corr_cnt", 32'(corr_cnt), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Directed corrected case with latency check
    drain();
    applyStimulus(4'h2, 5'b11101, 5'd4);
    @(negedge clk); #1;
    checkOutput("lat_t0", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    checkOutput("lat_t1", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    checkOutput("lat_t2", 32'(out_valid), 32'd1);
    checkOutput("req037_r", 32'(out_r), 32'd1);
    checkOutput("req037_fix", 32'(out_fix), 32'd1);

    // Pass-through and divide-by-zero, also checks one accept per 3 cycles
    drain();
    applyStimulus(4'h3, 5'd2, 5'd3);
    t0 = acc_time;
    applyStimulus(4'h7, 5'd6, 5'd0);
    checkOutput("throughput", 32'(acc_time - t0), 32'd30);
    drain();

    // Backpressure: two fill the FIFO, the third waits until the first pop
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(4'h1, 5'b10000, 5'd7);
    applyStimulus(4'h5, 5'd9, 5'd2);
    @(negedge clk);
    in_valid = 1'b1;
    in_q = 4'hA;
    in_r = 5'b11110;
    in_m = 5'd3;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("full_before_pop", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    checkOutput("ready_after_pop", 32'(in_ready), 32'd1);
    if (in_ready) exp_q.push_back(model(4'hA, 5'b11110, 5'd3));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Reset while in FIX discards the in-flight result
    applyStimulus(4'h4, 5'b11000, 5'd9);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("rst_fix_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_fix_ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rst_fix_no_out", 32'(out_valid), 32'd0);
      @(negedge clk); #1;
    end

    // Randomized traffic with random backpressure
    rand_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [WQ-1:0] rq;
      logic [WR-1:0] rr;
      logic [WR-1:0] rm;
      rq = WQ'($urandom);
      rr = WR'($urandom);
      rm = ($urandom_range(0, 5) == 0) ? '0 : WR'($urandom);
      applyStimulus(rq, rr, rm);
    end
    drain();

`ifdef DIV_RESULT_CORR_CNT_EN
    // Counter saturation after many corrected results
    for (int i = 0; i < 300; i++) begin
      applyStimulus(WQ'(i), 5'b11111, 5'd1);
    end
    drain();
    checkOutput("corr_cnt_sat", 32'(corr_cnt), 32'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
